// File: rtl/penguen_koloni_if.sv
// penguen_koloni_if: catch/enable inputs and scoring outputs of the penguin colony hunt tracker
// Parameters: N channels, W catch width per channel, SW cycle/finish-time width.
// master: drives etkin/avlanan_balik, observes results. slave: the scoring core.
interface penguen_koloni_if #(
  parameter int N  = 4,
  parameter int W  = 3,
  parameter int SW = 7
);
  logic [N-1:0]    etkin;
  logic [N*W-1:0]  avlanan_balik;
  logic [N-1:0]    bitti;
  logic [N*SW-1:0] bitme_sure;
  logic            hepsi_bitti;
  logic [3:0]      ilk_bitiren;
  logic            ilk_gecerli;
  logic            zaman_asimi;
  modport master (
    output etkin, avlanan_balik,
    input  bitti, bitme_sure, hepsi_bitti, ilk_bitiren, ilk_gecerli, zaman_asimi
  );
  modport slave (
    input  etkin, avlanan_balik,
    output bitti, bitme_sure, hepsi_bitti, ilk_bitiren, ilk_gecerli, zaman_asimi
  );
endinterface

// File: rtl/penguen_koloni.sv
// penguen_koloni: N-channel penguin hunt scoring core (per-channel fish totals, finish times, first finisher, timeout)
// Ports: saat clock (rising edge); reset async active-low; bus (slave) carries
//   etkin/avlanan_balik in, bitti/bitme_sure/hepsi_bitti/ilk_bitiren/ilk_gecerli/zaman_asimi out.
module penguen_koloni #(
  parameter int N           = 4,
  parameter int W           = 3,
  parameter int HEDEF       = 20,
  parameter int SW          = 7,
  parameter int ZAMAN_ASIMI = 100
) (
  input logic             saat,
  input logic             reset,
  penguen_koloni_if.slave bus
);
  localparam int TW = $clog2(HEDEF + 2**W);
  logic [SW-1:0]         sure_q, sure_d, sure_n;
  logic [N-1:0][TW-1:0]  toplam_q, toplam_d, sum;
  logic [N-1:0][SW-1:0]  bitme_sure_q, bitme_sure_d;
  logic [N-1:0]          bitti_q, bitti_d, acc, fin;
  logic                  hepsi_bitti_q, hepsi_bitti_d;
  logic                  zaman_asimi_q, zaman_asimi_d;
  logic                  ilk_gecerli_q, ilk_gecerli_d;
  logic [3:0]            ilk_bitiren_q, ilk_bitiren_d, ilk_idx;
  logic                  run;
  always_comb begin
    run = !zaman_asimi_q && !hepsi_bitti_q;
    sure_n = sure_q + 1'b1;
    ilk_idx = '0;
    for (int i = 0; i < N; i++) begin
      acc[i] = run && bus.etkin[i] && !bitti_q[i];
      sum[i] = toplam_q[i] + TW'(bus.avlanan_balik[i*W +: W]);
      fin[i] = acc[i] && sum[i] >= TW'(HEDEF);
      toplam_d[i] = acc[i] ? (fin[i] ? TW'(HEDEF) : sum[i]) : toplam_q[i];
      bitme_sure_d[i] = fin[i] ? sure_n : bitme_sure_q[i];
    end
    // Scan downward so the lowest finishing index is the one left standing
    for (int i = N - 1; i >= 0; i--)
      if (fin[i]) ilk_idx = 4'(i);
    bitti_d = bitti_q | fin;
    hepsi_bitti_d = &bitti_d;
    // Timeout only when this edge's updates still leave someone unfinished
    zaman_asimi_d = zaman_asimi_q | (run && sure_n == SW'(ZAMAN_ASIMI) && !(&bitti_d));
    sure_d = run ? sure_n : sure_q;
    ilk_gecerli_d = ilk_gecerli_q | (|fin);
    ilk_bitiren_d = (!ilk_gecerli_q && |fin) ? ilk_idx : ilk_bitiren_q;
  end
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      sure_q        <= '0;
      toplam_q      <= '0;
      bitme_sure_q  <= '0;
      bitti_q       <= '0;
      hepsi_bitti_q <= 1'b0;
      zaman_asimi_q <= 1'b0;
      ilk_gecerli_q <= 1'b0;
      ilk_bitiren_q <= '0;
    end else begin
      sure_q        <= sure_d;
      toplam_q      <= toplam_d;
      bitme_sure_q  <= bitme_sure_d;
      bitti_q       <= bitti_d;
      hepsi_bitti_q <= hepsi_bitti_d;
      zaman_asimi_q <= zaman_asimi_d;
      ilk_gecerli_q <= ilk_gecerli_d;
      ilk_bitiren_q <= ilk_bitiren_d;
    end
  end
  assign bus.bitti       = bitti_q;
  assign bus.bitme_sure  = bitme_sure_q;
  assign bus.hepsi_bitti = hepsi_bitti_q;
  assign bus.zaman_asimi = zaman_asimi_q;
  assign bus.ilk_gecerli = ilk_gecerli_q;
  assign bus.ilk_bitiren = ilk_bitiren_q;
endmodule

// File: tb/tb_penguen_koloni.sv
// tb_penguen_koloni: directed checks of penguen_koloni on a long-timeout instance (a) and a timeout-10 instance (b)
module tb_penguen_koloni;
  logic saat = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 saat = ~saat;
  penguen_koloni_if #(.N(2), .W(3), .SW(7)) ia ();
  penguen_koloni_if #(.N(2), .W(3), .SW(7)) ib ();
  penguen_koloni #(.N(2), .W(3), .HEDEF(20), .SW(7), .ZAMAN_ASIMI(100)) dut_a (
    .saat(saat), .reset(reset), .bus(ia.slave));
  penguen_koloni #(.N(2), .W(3), .HEDEF(20), .SW(7), .ZAMAN_ASIMI(10)) dut_b (
    .saat(saat), .reset(reset), .bus(ib.slave));
  task automatic edges(input int n);
    repeat (n) @(posedge saat);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    ia.etkin = '0; ia.avlanan_balik = '0;
    ib.etkin = '0; ib.avlanan_balik = '0;
    @(negedge saat);
    @(negedge saat);
    reset = 1'b1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({ia.bitti, ia.bitme_sure, ia.hepsi_bitti, ia.ilk_bitiren, ia.ilk_gecerli, ia.zaman_asimi} !== '0) begin
      failures++;
      $display("FAIL reset_a got bitti=%b sure=%h hepsi=%b ilk=%0d gec=%b za=%b want all 0",
        ia.bitti, ia.bitme_sure, ia.hepsi_bitti, ia.ilk_bitiren, ia.ilk_gecerli, ia.zaman_asimi);
    end
    checks++;
    if ({ib.bitti, ib.bitme_sure, ib.hepsi_bitti, ib.ilk_gecerli, ib.zaman_asimi} !== '0) begin
      failures++;
      $display("FAIL reset_b got bitti=%b sure=%h want 0", ib.bitti, ib.bitme_sure);
    end
  endtask
  task automatic test_basic();
    do_reset();
    ia.etkin = 2'b11; ia.avlanan_balik = {3'd1, 3'd7};
    edges(2);
    checks++;
    if (ia.bitti !== 2'b00) begin failures++; $display("FAIL basic_e2_bitti got %b want 00", ia.bitti); end
    edges(1);
    checks++;
    if (ia.bitti !== 2'b01 || ia.bitme_sure !== {7'd0, 7'd3}) begin
      failures++; $display("FAIL basic_e3 got bitti=%b sure=%h want 01 %h", ia.bitti, ia.bitme_sure, {7'd0, 7'd3});
    end
    checks++;
    if (ia.ilk_gecerli !== 1'b1 || ia.ilk_bitiren !== 4'd0 || ia.hepsi_bitti !== 1'b0) begin
      failures++; $display("FAIL basic_ilk got gec=%b ilk=%0d hepsi=%b want 1 0 0", ia.ilk_gecerli, ia.ilk_bitiren, ia.hepsi_bitti);
    end
    edges(16);
    checks++;
    if (ia.bitti !== 2'b01 || ia.hepsi_bitti !== 1'b0) begin
      failures++; $display("FAIL basic_e19 got bitti=%b hepsi=%b want 01 0", ia.bitti, ia.hepsi_bitti);
    end
    edges(1);
    checks++;
    if (ia.bitti !== 2'b11 || ia.bitme_sure !== {7'd20, 7'd3} || ia.hepsi_bitti !== 1'b1) begin
      failures++; $display("FAIL basic_e20 got bitti=%b sure=%h hepsi=%b want 11 %h 1", ia.bitti, ia.bitme_sure, ia.hepsi_bitti, {7'd20, 7'd3});
    end
    edges(5);
    checks++;
    if (ia.bitti !== 2'b11 || ia.bitme_sure !== {7'd20, 7'd3} || ia.hepsi_bitti !== 1'b1 || ia.ilk_bitiren !== 4'd0 || ia.zaman_asimi !== 1'b0) begin
      failures++; $display("FAIL basic_frozen got bitti=%b sure=%h hepsi=%b ilk=%0d za=%b", ia.bitti, ia.bitme_sure, ia.hepsi_bitti, ia.ilk_bitiren, ia.zaman_asimi);
    end
  endtask
  task automatic test_tie();
    do_reset();
    ia.etkin = 2'b11; ia.avlanan_balik = {3'd5, 3'd5};
    edges(3);
    checks++;
    if (ia.bitti !== 2'b00) begin failures++; $display("FAIL tie_e3 got bitti=%b want 00", ia.bitti); end
    edges(1);
    checks++;
    if (ia.bitti !== 2'b11 || ia.bitme_sure !== {7'd4, 7'd4} || ia.hepsi_bitti !== 1'b1 || ia.ilk_bitiren !== 4'd0 || ia.ilk_gecerli !== 1'b1) begin
      failures++; $display("FAIL tie_e4 got bitti=%b sure=%h hepsi=%b ilk=%0d gec=%b", ia.bitti, ia.bitme_sure, ia.hepsi_bitti, ia.ilk_bitiren, ia.ilk_gecerli);
    end
  endtask
  task automatic test_first_high();
    do_reset();
    ia.etkin = 2'b11; ia.avlanan_balik = {3'd7, 3'd0};
    edges(3);
    checks++;
    if (ia.bitti !== 2'b10 || ia.bitme_sure !== {7'd3, 7'd0} || ia.ilk_bitiren !== 4'd1 || ia.ilk_gecerli !== 1'b1) begin
      failures++; $display("FAIL first_high got bitti=%b sure=%h ilk=%0d gec=%b want 10 %h 1 1", ia.bitti, ia.bitme_sure, ia.ilk_bitiren, ia.ilk_gecerli, {7'd3, 7'd0});
    end
    ia.avlanan_balik = {3'd0, 3'd7};
    edges(3);
    checks++;
    if (ia.ilk_bitiren !== 4'd1 || ia.bitme_sure !== {7'd3, 7'd6}) begin
      failures++; $display("FAIL first_sticky got ilk=%0d sure=%h want 1 %h", ia.ilk_bitiren, ia.bitme_sure, {7'd3, 7'd6});
    end
  endtask
  task automatic test_gating();
    do_reset();
    ia.etkin = 2'b00; ia.avlanan_balik = {3'd7, 3'd7};
    edges(5);
    ia.etkin = 2'b01;
    edges(2);
    checks++;
    if (ia.bitti !== 2'b00) begin failures++; $display("FAIL gate_e7 got bitti=%b want 00", ia.bitti); end
    edges(1);
    checks++;
    if (ia.bitti !== 2'b01 || ia.bitme_sure !== {7'd0, 7'd8}) begin
      failures++; $display("FAIL gate_e8 got bitti=%b sure=%h want 01 %h", ia.bitti, ia.bitme_sure, {7'd0, 7'd8});
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    ia.etkin = 2'b01; ia.avlanan_balik = {3'd0, 3'd7};
    edges(2);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ia.bitti, ia.bitme_sure, ia.ilk_gecerli} !== '0) begin
      failures++; $display("FAIL async_mid got bitti=%b sure=%h gec=%b want 0", ia.bitti, ia.bitme_sure, ia.ilk_gecerli);
    end
    @(negedge saat);
    reset = 1'b1;
    edges(2);
    checks++;
    if (ia.bitti !== 2'b00) begin failures++; $display("FAIL async_restart_e2 got bitti=%b want 00", ia.bitti); end
    edges(1);
    checks++;
    if (ia.bitti !== 2'b01 || ia.bitme_sure !== {7'd0, 7'd3}) begin
      failures++; $display("FAIL async_restart_e3 got bitti=%b sure=%h want 01 %h", ia.bitti, ia.bitme_sure, {7'd0, 7'd3});
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({ia.bitti, ia.bitme_sure, ia.ilk_gecerli} !== '0) begin
      failures++; $display("FAIL async_done got bitti=%b sure=%h gec=%b want 0", ia.bitti, ia.bitme_sure, ia.ilk_gecerli);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    ib.etkin = 2'b11; ib.avlanan_balik = {3'd0, 3'd7};
    edges(9);
    checks++;
    if (ib.zaman_asimi !== 1'b0 || ib.bitti !== 2'b01) begin
      failures++; $display("FAIL timeout_e9 got za=%b bitti=%b want 0 01", ib.zaman_asimi, ib.bitti);
    end
    edges(1);
    checks++;
    if (ib.zaman_asimi !== 1'b1 || ib.bitti !== 2'b01 || ib.hepsi_bitti !== 1'b0 || ib.bitme_sure !== {7'd0, 7'd3}) begin
      failures++; $display("FAIL timeout_e10 got za=%b bitti=%b hepsi=%b sure=%h", ib.zaman_asimi, ib.bitti, ib.hepsi_bitti, ib.bitme_sure);
    end
    ib.avlanan_balik = {3'd7, 3'd7};
    edges(20);
    checks++;
    if (ib.zaman_asimi !== 1'b1 || ib.bitti !== 2'b01 || ib.hepsi_bitti !== 1'b0 || ib.bitme_sure !== {7'd0, 7'd3}) begin
      failures++; $display("FAIL timeout_hold got za=%b bitti=%b hepsi=%b sure=%h", ib.zaman_asimi, ib.bitti, ib.hepsi_bitti, ib.bitme_sure);
    end
  endtask
  task automatic test_timeout_last();
    do_reset();
    ib.etkin = 2'b11; ib.avlanan_balik = {3'd2, 3'd7};
    edges(10);
    checks++;
    if (ib.bitti !== 2'b11 || ib.bitme_sure !== {7'd10, 7'd3} || ib.hepsi_bitti !== 1'b1 || ib.zaman_asimi !== 1'b0) begin
      failures++; $display("FAIL timeout_last got bitti=%b sure=%h hepsi=%b za=%b want 11 %h 1 0", ib.bitti, ib.bitme_sure, ib.hepsi_bitti, ib.zaman_asimi, {7'd10, 7'd3});
    end
  endtask
  initial begin
    ia.etkin = '0; ia.avlanan_balik = '0;
    ib.etkin = '0; ib.avlanan_balik = '0;
    test_reset();
    test_basic();
    test_tie();
    test_first_high();
    test_gating();
    test_async_reset();
    test_timeout();
    test_timeout_last();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/penguen_koloni.md
Name: penguen_koloni

Overview:
- Multi-channel successor to the single-penguin hunt tracker: N penguins hunt in parallel, each accumulating caught fish per clock until reaching a target.
- Per penguin: done flag and finish time. Colony level: global cycle counter, all-done flag, first-finisher index and timeout.
- Sits in the final-exam lab design as the scoring core fed by per-cycle catch inputs.

Parameters:
- N, 4, number of penguins (channels), 1..16
- W, 3, width of each per-penguin catch input
- HEDEF, 20, fish total at which a penguin is finished
- SW, 7, width of the cycle counter and finish-time fields
- ZAMAN_ASIMI, 100, cycle count at which the hunt times out (must be < 2^SW)

Ports:
- saat  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- etkin  in  N  per-penguin hunt enable; bit i gates channel i
- avlanan_balik  in  N*W  packed catches; channel i = bits [i*W+W-1 : i*W]
- bitti  out  N  per-penguin done flags
- bitme_sure  out  N*SW  packed finish times, channel i = bits [i*SW+SW-1 : i*SW]
- hepsi_bitti  out  1  all N penguins done
- ilk_bitiren  out  4  index of first penguin to finish
- ilk_gecerli  out  1  ilk_bitiren is valid
- zaman_asimi  out  1  hunt timed out before all penguins finished

Behaviour:
- Reset (reset=0, asynchronous): sure=0; every toplam_i=0; bitti=0; bitme_sure=0; hepsi_bitti=0; ilk_bitiren=0; ilk_gecerli=0; zaman_asimi=0. Outputs are forced immediately, not at the next edge.
- Run state: reset=1, not zaman_asimi, not hepsi_bitti. Each rising edge:
  - sure <= sure+1.
  - For each i with etkin[i]=1 and bitti[i]=0: toplam_i <= toplam_i + avlanan_balik_i.
  - toplam_i saturates at HEDEF; its internal width is clog2(HEDEF+2^W).
- Finish detect:
  - Condition: toplam_i + avlanan_balik_i >= HEDEF on an edge where channel i is accumulating.
  - On that same edge: bitti[i] <= 1 and bitme_sure_i <= sure+1. The first edge after reset release therefore reports time 1.
  - Latched until reset; further catches on channel i are ignored.
- etkin[i]=0: that channel's catch is discarded; sure still advances.
- First finisher:
  - On the first edge where any channel finishes: ilk_gecerli <= 1 and ilk_bitiren <= lowest finishing index.
  - Simultaneous finishers: the lowest index wins.
  - Never updated afterwards.
- hepsi_bitti: set on the edge where the last not-done channel finishes; the block then freezes (sure stops).
- Timeout:
  - Condition: sure+1 == ZAMAN_ASIMI and not all done after this edge's updates.
  - On that edge: zaman_asimi <= 1; the block freezes (sure stops, no further accumulation).
  - Any channel finishing on that same edge is still recorded with bitme_sure = ZAMAN_ASIMI.
  - If the last channel finishes on that edge: hepsi_bitti=1 and zaman_asimi=0.
- Frozen state: all outputs hold until reset.
- Reset mid-hunt: immediate return to reset values; counting restarts from the first edge after release.
- Zero catch (avlanan_balik_i=0): a legal non-event.
- Catch of 2^W-1 that overshoots HEDEF: still finishes on that edge.

Test Plan:
- N=2, W=3, HEDEF=20, etkin=11, ch0=7 and ch1=1 every cycle -> bitti[0]=1 after edge 3 with bitme_sure_0=3, ilk_bitiren=0, ilk_gecerli=1; bitti[1]=1 at edge 20 with bitme_sure_1=20; hepsi_bitti=1 and sure frozen.
- Tie: ch0=5, ch1=5 every cycle -> both finish at edge 4 (bitme_sure=4); ilk_bitiren=0; hepsi_bitti=1 on that edge.
- Enable gating: ch0=7 with etkin[0]=0 for 5 cycles, then etkin[0]=1 -> bitme_sure_0=8.
- Timeout: ZAMAN_ASIMI=10, ch1 fed 0 throughout -> zaman_asimi=1 after edge 10, bitti[1]=0; outputs unchanged 20 cycles later.
- Async reset mid-hunt: drop reset between edges at cycle 2 -> all outputs 0 before the next edge; after release, ch0=7 finishes at edge 3 again.
- Last finisher on the timeout edge (ZAMAN_ASIMI=10, ch1=2 every cycle) -> bitme_sure_1=10, hepsi_bitti=1, zaman_asimi=0.
